// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port (uart_memory) among N_CH
// requester channels. Each channel latches one request at a time; a small
// IDLE/ISSUE/WAIT FSM forwards one pending request downstream, waits for its
// completion (or an optional timeout) and reports back on the owning channel.
//
// Handshake: a channel request is a one-cycle ch_start pulse, accepted only
// while that channel's ch_busy is low. ch_busy stays high until the cycle in
// which ch_done pulses. Downstream, m_start and m_* are held stable until a
// cycle with m_busy low, after which the arbiter waits for a one-cycle m_done.
module mem_arbiter #(
  parameter int N_CH    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   ch_start,
  input  logic [N_CH*AW-1:0] ch_adr,
  input  logic [N_CH-1:0]   ch_load,
  input  logic [N_CH*DW-1:0] ch_in,
  input  logic [N_CH*3-1:0] ch_siz,
  output logic [N_CH-1:0]   ch_busy,
  output logic [N_CH-1:0]   ch_done,
  output logic [DW-1:0]     ch_out,
  output logic              ch_err,
  output logic              m_start,
  output logic [AW-1:0]     m_adr,
  output logic              m_load,
  output logic [DW-1:0]     m_in,
  output logic [2:0]        m_siz,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic [DW-1:0]     m_out,
  output logic [1:0]        dbg_state
);

  localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
  localparam logic [N_CH-1:0] ONE_HOT0 = N_CH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          r_state;
  logic [N_CH-1:0] r_pend;
  logic [AW-1:0]   r_adr [N_CH];
  logic [N_CH-1:0] r_load;
  logic [DW-1:0]   r_in  [N_CH];
  logic [2:0]      r_siz [N_CH];
  logic [GW-1:0]   r_gnt;
  logic [GW-1:0]   r_rr;
  logic [31:0]     r_cnt;
  logic [N_CH-1:0] r_ch_done;
  logic [DW-1:0]   r_ch_out;
  logic            r_ch_err;
  logic            r_m_start;
  logic [AW-1:0]   r_m_adr;
  logic            r_m_load;
  logic [DW-1:0]   r_m_in;
  logic [2:0]      r_m_siz;

  logic [GW-1:0]   w_gnt;
  logic [GW-1:0]   w_idx;
  logic            w_any;
  logic            w_timeout;
  logic            w_finish;

  // Grant selection from the current pending set (fixed priority or round-robin).
  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    w_any = |r_pend;
    if (MODE == 0) begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        w_idx = GW'(i);
        if (r_pend[w_idx]) w_gnt = w_idx;
      end
    end else begin
      // Walk from farthest to nearest so the first index after r_rr wins.
      for (int k = N_CH; k >= 1; k--) begin
        w_idx = GW'((int'(r_rr) + k) % N_CH);
        if (r_pend[w_idx]) w_gnt = w_idx;
      end
    end
  end

  assign w_timeout = (TIMEOUT > 0) && (r_state == S_WAIT) && !m_done && (r_cnt == TO_LAST);
  assign w_finish  = (r_state == S_WAIT) && (m_done || w_timeout);

  // Per-channel request capture; the granted entry is released when it finishes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
      r_load <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_adr[i] <= '0;
        r_in[i]  <= '0;
        r_siz[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_start[i] && !r_pend[i]) begin
          r_pend[i] <= 1'b1;
          r_adr[i]  <= ch_adr[i*AW +: AW];
          r_load[i] <= ch_load[i];
          r_in[i]   <= ch_in[i*DW +: DW];
          r_siz[i]  <= ch_siz[i*3 +: 3];
        end else if (w_finish && (r_gnt == GW'(i))) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Arbitration FSM with registered downstream and completion outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_rr      <= GW'(N_CH - 1);
      r_cnt     <= '0;
      r_ch_done <= '0;
      r_ch_out  <= '0;
      r_ch_err  <= 1'b0;
      r_m_start <= 1'b0;
      r_m_adr   <= '0;
      r_m_load  <= 1'b0;
      r_m_in    <= '0;
      r_m_siz   <= '0;
    end else begin
      r_ch_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt     <= w_gnt;
            r_m_start <= 1'b1;
            r_m_adr   <= r_adr[w_gnt];
            r_m_load  <= r_load[w_gnt];
            r_m_in    <= r_in[w_gnt];
            r_m_siz   <= r_siz[w_gnt];
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!m_busy) begin
            r_m_start <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (m_done) begin
            r_ch_done <= ONE_HOT0 << r_gnt;
            r_ch_out  <= m_out;
            r_ch_err  <= 1'b0;
            r_rr      <= r_gnt;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
          end else if (w_timeout) begin
            r_ch_done <= ONE_HOT0 << r_gnt;
            r_ch_out  <= '0;
            r_ch_err  <= 1'b1;
            r_rr      <= r_gnt;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
          end else if (TIMEOUT > 0) begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch_busy   = r_pend;
  assign ch_done   = r_ch_done;
  assign ch_out    = r_ch_out;
  assign ch_err    = r_ch_err;
  assign m_start   = r_m_start;
  assign m_adr     = r_m_adr;
  assign m_load    = r_m_load;
  assign m_in      = r_m_in;
  assign m_siz     = r_m_siz;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance a is fixed priority with an 8-cycle
// timeout, instance b is round-robin without timeout. Both share the channel
// inputs; each has its own m_done so only the targeted instance completes.
module tb_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  ch_start = '0;
  logic [N*AW-1:0] ch_adr = '0;
  logic [N-1:0]  ch_load = '0;
  logic [N*DW-1:0] ch_in = '0;
  logic [N*3-1:0] ch_siz = '0;
  logic          m_busy = 1'b0;
  logic          m_done_a = 1'b0;
  logic          m_done_b = 1'b0;
  logic [DW-1:0] m_out = '0;

  logic [N-1:0]  a_busy, a_done, b_busy, b_done;
  logic [DW-1:0] a_out, b_out, a_min, b_min;
  logic          a_err, b_err, a_mstart, b_mstart, a_mload, b_mload;
  logic [AW-1:0] a_madr, b_madr;
  logic [2:0]    a_msiz, b_msiz;
  logic [1:0]    a_dbg, b_dbg;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          ch;
    logic [31:0] adr;
    logic        load;
    logic [31:0] din;
    logic [2:0]  siz;
    logic [31:0] resp;
    logic [31:0] exp_madr;
    logic        exp_mload;
    logic [31:0] exp_min;
    logic [2:0]  exp_msiz;
    logic [2:0]  exp_done;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs [4];
  int   rr_exp [6];

  always #5 clk = ~clk;

  mem_arbiter #(.N_CH(N), .AW(AW), .DW(DW), .MODE(0), .TIMEOUT(8)) u_a (
    .clk(clk), .rst(rst), .ch_start(ch_start), .ch_adr(ch_adr), .ch_load(ch_load),
    .ch_in(ch_in), .ch_siz(ch_siz), .ch_busy(a_busy), .ch_done(a_done), .ch_out(a_out),
    .ch_err(a_err), .m_start(a_mstart), .m_adr(a_madr), .m_load(a_mload), .m_in(a_min),
    .m_siz(a_msiz), .m_busy(m_busy), .m_done(m_done_a), .m_out(m_out), .dbg_state(a_dbg)
  );

  mem_arbiter #(.N_CH(N), .AW(AW), .DW(DW), .MODE(1), .TIMEOUT(0)) u_b (
    .clk(clk), .rst(rst), .ch_start(ch_start), .ch_adr(ch_adr), .ch_load(ch_load),
    .ch_in(ch_in), .ch_siz(ch_siz), .ch_busy(b_busy), .ch_done(b_done), .ch_out(b_out),
    .ch_err(b_err), .m_start(b_mstart), .m_adr(b_madr), .m_load(b_mload), .m_in(b_min),
    .m_siz(b_msiz), .m_busy(m_busy), .m_done(m_done_b), .m_out(m_out), .dbg_state(b_dbg)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic [31:0] adr, input logic load,
                         input logic [31:0] din, input logic [2:0] siz);
    ch_adr[c*AW +: AW] = adr;
    ch_load[c]         = load;
    ch_in[c*DW +: DW]  = din;
    ch_siz[c*3 +: 3]   = siz;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Global time bound so the bench always reaches its summary.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    int  cnt;
    bit  seen;

    vecs[0] = '{0, 32'h0000_1000, 1'b1, 32'h0,         3'd4, 32'h0BAD_F00D,
                32'h0000_1000, 1'b1, 32'h0,         3'd4, 3'b001, 32'h0BAD_F00D};
    vecs[1] = '{1, 32'h0000_2004, 1'b0, 32'h1234_5678, 3'd4, 32'h0,
                32'h0000_2004, 1'b0, 32'h1234_5678, 3'd4, 3'b010, 32'h0};
    vecs[2] = '{2, 32'h0000_3001, 1'b1, 32'h0,         3'd1, 32'h0000_00AB,
                32'h0000_3001, 1'b1, 32'h0,         3'd1, 3'b100, 32'h0000_00AB};
    vecs[3] = '{2, 32'h0000_3002, 1'b0, 32'h0000_FFFF, 3'd2, 32'h0000_0077,
                32'h0000_3002, 1'b0, 32'h0000_FFFF, 3'd2, 3'b100, 32'h0000_0077};
    rr_exp = '{0, 1, 2, 0, 1, 2};

    // ---- reset values
    #1;
    do_reset();
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_out", a_out, 0);
    chk("rst_err", a_err, 0);
    chk("rst_mstart", a_mstart, 0);
    chk("rst_madr", a_madr, 0);
    chk("rst_mload", a_mload, 0);
    chk("rst_min", a_min, 0);
    chk("rst_msiz", a_msiz, 0);
    chk("rst_state", a_dbg, 0);

    // ---- round-robin on instance b: all channels request, each re-requests in its done cycle
    for (int c = 0; c < N; c++) set_req(c, 32'h4000 + 32'(c) * 32'h100, 1'b1, 32'h0, 3'd4);
    ch_start = 3'b111;
    tick();
    ch_start = '0;
    for (int t = 0; t < 6; t++) begin
      seen = 1'b0;
      for (int w = 0; w < 20; w++) begin
        if (b_mstart) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      chk("rr_mstart_seen", seen, 1);
      chk("rr_grant_adr", b_madr, 32'h4000 + 32'(rr_exp[t]) * 32'h100);
      tick();
      m_out    = 32'hA0 + 32'(t);
      m_done_b = 1'b1;
      tick();
      m_done_b = 1'b0;
      chk("rr_done", b_done, 3'b001 << rr_exp[t]);
      chk("rr_out", b_out, 32'hA0 + 32'(t));
      ch_start = 3'b001 << rr_exp[t];
      tick();
      ch_start = '0;
    end

    // ---- cycle-exact single read on instance a
    do_reset();
    set_req(0, 32'h100, 1'b1, 32'h0, 3'd4);
    ch_start = 3'b001;
    tick();
    ch_start = '0;
    chk("sr_c1_mstart", a_mstart, 0);
    chk("sr_c1_busy", a_busy, 3'b001);
    tick();
    chk("sr_c2_mstart", a_mstart, 1);
    chk("sr_c2_madr", a_madr, 32'h100);
    chk("sr_c2_mload", a_mload, 1);
    chk("sr_c2_msiz", a_msiz, 3'd4);
    for (int c = 3; c <= 5; c++) begin
      tick();
      chk("sr_wait_mstart", a_mstart, 0);
      chk("sr_wait_done", a_done, 0);
    end
    tick();
    m_out    = 32'hDEAD_BEEF;
    m_done_a = 1'b1;
    tick();
    m_done_a = 1'b0;
    chk("sr_c7_done", a_done, 3'b001);
    chk("sr_c7_out", a_out, 32'hDEAD_BEEF);
    chk("sr_c7_err", a_err, 0);
    chk("sr_c7_busy", a_busy, 0);
    tick();
    chk("sr_c8_done", a_done, 0);
    chk("sr_c8_out_hold", a_out, 32'hDEAD_BEEF);

    // ---- table-driven single transactions on instance a
    for (int v = 0; v < 4; v++) begin
      set_req(vecs[v].ch, vecs[v].adr, vecs[v].load, vecs[v].din, vecs[v].siz);
      ch_start = 3'b001 << vecs[v].ch;
      tick();
      ch_start = '0;
      chk("tv_busy", a_busy, vecs[v].exp_done);
      tick();
      chk("tv_mstart", a_mstart, 1);
      chk("tv_madr", a_madr, vecs[v].exp_madr);
      chk("tv_mload", a_mload, vecs[v].exp_mload);
      chk("tv_min", a_min, vecs[v].exp_min);
      chk("tv_msiz", a_msiz, vecs[v].exp_msiz);
      tick();
      chk("tv_mstart_low", a_mstart, 0);
      m_out    = vecs[v].resp;
      m_done_a = 1'b1;
      tick();
      m_done_a = 1'b0;
      chk("tv_done", a_done, vecs[v].exp_done);
      chk("tv_out", a_out, vecs[v].exp_out);
      chk("tv_err", a_err, 0);
      chk("tv_busy_clr", a_busy, 0);
      tick();
      chk("tv_done_pulse", a_done, 0);
    end

    // ---- fixed priority: ch2 and ch0 together, ch0 first
    set_req(0, 32'hA00, 1'b1, 32'h0, 3'd4);
    set_req(2, 32'hC00, 1'b0, 32'hBBBB, 3'd2);
    ch_start = 3'b101;
    tick();
    ch_start = '0;
    chk("fp_busy", a_busy, 3'b101);
    tick();
    chk("fp_first_adr", a_madr, 32'hA00);
    tick();
    m_out    = 32'h1111;
    m_done_a = 1'b1;
    tick();
    m_done_a = 1'b0;
    chk("fp_first_done", a_done, 3'b001);
    chk("fp_first_out", a_out, 32'h1111);
    chk("fp_busy_left", a_busy, 3'b100);
    tick();
    chk("fp_second_mstart", a_mstart, 1);
    chk("fp_second_adr", a_madr, 32'hC00);
    chk("fp_second_min", a_min, 32'hBBBB);
    chk("fp_second_msiz", a_msiz, 3'd2);
    tick();
    m_out    = 32'h2222;
    m_done_a = 1'b1;
    tick();
    m_done_a = 1'b0;
    chk("fp_second_done", a_done, 3'b100);

    // ---- downstream busy stall; a second ch0 start while busy is dropped
    m_busy = 1'b1;
    set_req(0, 32'h200, 1'b0, 32'h1122_3344, 3'd4);
    ch_start = 3'b001;
    tick();
    ch_start = '0;
    tick();
    chk("bs_c2_mstart", a_mstart, 1);
    chk("bs_c2_madr", a_madr, 32'h200);
    set_req(0, 32'h300, 1'b1, 32'h0, 3'd1);
    ch_start = 3'b001;
    tick();
    ch_start = '0;
    for (int c = 3; c <= 5; c++) begin
      chk("bs_hold_mstart", a_mstart, 1);
      chk("bs_hold_madr", a_madr, 32'h200);
      chk("bs_hold_min", a_min, 32'h1122_3344);
      tick();
    end
    m_busy = 1'b0;
    chk("bs_c6_mstart", a_mstart, 1);
    chk("bs_c6_state", a_dbg, 2'd1);
    tick();
    chk("bs_c7_mstart", a_mstart, 0);
    chk("bs_c7_state", a_dbg, 2'd2);
    m_out    = 32'hCAFE_0001;
    m_done_a = 1'b1;
    tick();
    m_done_a = 1'b0;
    chk("bs_done", a_done, 3'b001);
    chk("bs_out", a_out, 32'hCAFE_0001);
    cnt  = 0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (a_done != 0) cnt++;
      if (a_mstart) seen = 1'b1;
    end
    chk("bs_extra_done", cnt, 0);
    chk("bs_extra_issue", seen, 0);

    // ---- timeout: ch1 never completes, ch2 pending behind it
    set_req(1, 32'hB10, 1'b1, 32'h0, 3'd4);
    set_req(2, 32'hC20, 1'b1, 32'h0, 3'd1);
    ch_start = 3'b110;
    tick();
    ch_start = '0;
    tick();
    chk("to_first_adr", a_madr, 32'hB10);
    tick();
    chk("to_wait_state", a_dbg, 2'd2);
    cnt = 0;
    for (int c = 4; c <= 10; c++) begin
      tick();
      if (a_done != 0) cnt++;
    end
    chk("to_early_done", cnt, 0);
    tick();
    chk("to_done", a_done, 3'b010);
    chk("to_err", a_err, 1);
    chk("to_out", a_out, 0);
    chk("to_busy", a_busy, 3'b100);
    tick();
    chk("to_next_mstart", a_mstart, 1);
    chk("to_next_adr", a_madr, 32'hC20);
    chk("to_err_hold", a_err, 1);
    chk("to_done_pulse", a_done, 0);
    tick();
    m_out    = 32'h55AA;
    m_done_a = 1'b1;
    tick();
    m_done_a = 1'b0;
    chk("to_next_done", a_done, 3'b100);
    chk("to_next_err", a_err, 0);
    chk("to_next_out", a_out, 32'h55AA);

    // ---- asynchronous reset while waiting
    set_req(0, 32'h100, 1'b1, 32'h0, 3'd4);
    ch_start = 3'b001;
    tick();
    ch_start = '0;
    tick();
    tick();
    chk("ar_pre_state", a_dbg, 2'd2);
    chk("ar_pre_busy", a_busy, 3'b001);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_busy", a_busy, 0);
    chk("ar_state", a_dbg, 0);
    chk("ar_madr", a_madr, 0);
    chk("ar_mload", a_mload, 0);
    chk("ar_out", a_out, 0);
    chk("ar_err", a_err, 0);
    #2;
    rst = 1'b1;
    tick();
    m_out    = 32'h9999;
    m_done_a = 1'b1;
    tick();
    m_done_a = 1'b0;
    chk("ar_late_done", a_done, 0);
    tick();
    chk("ar_late_done2", a_done, 0);
    chk("ar_late_out", a_out, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- N-channel arbiter between CPU-side memory requesters (instruction fetch, load/store, future DMA) and the single uart_memory port.
- Parametrised successor to the fixed two-port I/D memory hookup: configurable channel count, address and data width, fixed-priority or round-robin mode, and an optional per-transaction timeout with an error flag.
- Sits between the core front-end (instr_ctrl, rsreg) and uart_memory.

Parameters:
- N_CH, 2, number of requester channels (1..8); channel 0 is instruction fetch by convention.
- AW, 32, address width.
- DW, 32, data width.
- MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT, 0, cycles in WAIT before abort; 0 disables.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ch_start  in  N_CH  per-channel request pulse.
- ch_adr  in  N_CH*AW  request address; channel i occupies [i*AW +: AW].
- ch_load  in  N_CH  1 = read, 0 = write.
- ch_in  in  N_CH*DW  write data.
- ch_siz  in  N_CH*3  access size in bytes (1, 2 or 4).
- ch_busy  out  N_CH  channel has an accepted, uncompleted request.
- ch_done  out  N_CH  one-cycle completion pulse.
- ch_out  out  DW  read data; valid in the ch_done cycle.
- ch_err  out  1  timeout flag; valid in the ch_done cycle.
- m_start  out  1  downstream request.
- m_adr  out  AW  downstream address.
- m_load  out  1  downstream read/write select.
- m_in  out  DW  downstream write data.
- m_siz  out  3  downstream access size.
- m_busy  in  1  downstream busy.
- m_done  in  1  downstream completion pulse.
- m_out  in  DW  downstream read data.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all pending entries cleared.
  - ch_busy=0, ch_done=0, ch_out=0, ch_err=0.
  - m_start=0, m_adr=0, m_load=0, m_in=0, m_siz=0.
  - rr pointer=N_CH-1; timeout counter=0.
  - Reset mid-transaction drops it silently. A late m_done after reset is ignored because state is IDLE.
- Capture:
  - ch_start[i] is accepted only when ch_busy[i]=0 in the same cycle; a start while busy is ignored.
  - On accept, adr/load/in/siz are latched into pending[i], and ch_busy[i]=1 from the next cycle.
- FSM states IDLE, ISSUE, WAIT; all outputs are registered.
  - IDLE: if any pending bit is set, pick grant g; next cycle state=ISSUE, m_start=1, and m_* driven from pending[g].
    - MODE 0: g = lowest pending index.
    - MODE 1: g = first pending index searching upward from rr+1, wrapping modulo N_CH.
  - ISSUE: hold m_start=1 and m_* stable until a cycle with m_busy=0; then state=WAIT and m_start=0 next cycle.
  - WAIT, on m_done=1:
    - next cycle ch_done[g]=1 for exactly one cycle, ch_out=m_out, ch_err=0;
    - pending[g] cleared and ch_busy[g]=0 in that same cycle;
    - rr=g; state=IDLE.
  - WAIT with TIMEOUT>0: the counter increments each WAIT cycle. When it reaches TIMEOUT without m_done:
    - ch_done[g]=1, ch_err=1, ch_out=0;
    - pending cleared; state=IDLE; counter cleared.
- Latency: ch_start at cycle 0 gives m_start=1 at cycle 2 with m_busy low and no contention; m_done at cycle k gives ch_done at k+1.
- Same-channel restart: ch_start[i] in the ch_done[i] cycle is accepted, since busy is already low.
- Requests arriving during ISSUE/WAIT stay pending and are arbitrated on the next IDLE visit.
- ch_out and ch_err hold their value outside done cycles; ch_done is 0 otherwise.
- Only one downstream transaction is ever outstanding.

Test Plan:
- Single read: ch0 start adr=0x100 siz=4; m_busy=0; m_done at cycle 6 with m_out=0xDEADBEEF -> m_start at cycle 2 with m_adr=0x100, m_load=1; ch_done[0] and ch_out=0xDEADBEEF at cycle 7; ch_busy[0] low at cycle 7.
- Fixed priority: MODE=0, N_CH=3, ch2 and ch0 start in the same cycle -> ch0 served first, then ch2; ch_done order 0, 2.
- Round-robin: MODE=1, N_CH=3, all channels re-request immediately after each done for 6 transactions -> grant order 0,1,2,0,1,2.
- Busy stall: m_busy=1 for 4 cycles during ISSUE -> m_start and m_adr held stable; WAIT entered only after m_busy=0; a second ch0 start while busy is ignored (exactly one done).
- Timeout: TIMEOUT=8, m_done never arrives -> ch_done[g]=1 with ch_err=1 eight WAIT cycles after ISSUE exit; the next pending request is issued.
- Async reset in WAIT: rst low mid-cycle -> all outputs 0 immediately; a later m_done produces no ch_done.
